// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM compare path and the future duty-register bus block.
package pwm_pkg;

    localparam int DEFAULT_BITS = 4;
    localparam int DUTY_W       = DEFAULT_BITS + 1;
    localparam int PERIOD       = 2 ** DEFAULT_BITS;

    // Valid/ready polarity: both active-high, transfer on a clk edge where both are asserted.
    localparam logic HS_ASSERTED   = 1'b1;
    localparam logic HS_DEASSERTED = 1'b0;

    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/dead_time_gen.sv
// Dead-time insertion: each output rises only after the raw level has held for DEAD cycles.
module dead_time_gen #(
    parameter int DEAD = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic pwm_o,
    output logic pwm_n_o
);

    localparam int RUN_W = $clog2(DEAD + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEAD);

    logic             raw_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             pwm_q;
    logic             pwm_n_q;
    logic             settled;

    // run_q counts cycles the raw level has been stable, saturating at DEAD.
    always_comb begin
        run_d = run_q;
        if (raw_i != raw_q) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
    end

    assign settled = (run_d == RUN_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q   <= 1'b0;
            run_q   <= '0;
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            raw_q   <= raw_i;
            run_q   <= run_d;
            pwm_q   <= raw_i && settled;
            pwm_n_q <= !raw_i && settled;
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pwm_compare_unit.sv
// PWM compare stage with double-buffered duty applied at period wrap.
// Define DEADTIME_EN to insert dead_time_gen between the compare and the outputs.
module pwm_compare_unit
    import pwm_pkg::*;
#(
    parameter int BITS = 4,
    parameter int DEAD = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [BITS-1:0] cnt_i,
    input  logic [BITS:0]   duty_i,
    input  logic            duty_valid_i,
    output logic            duty_ready_o,
    output logic            pwm_o,
    output logic            pwm_n_o,
    output logic            period_start_o
);

    localparam int DUTY_BITS  = BITS + 1;
    localparam int PERIOD_LEN = 2 ** BITS;
    localparam logic [BITS-1:0] CNT_LAST = BITS'(PERIOD_LEN - 1);

    if (DEAD < 1 || DEAD > PERIOD_LEN / 2) begin : g_bad_dead
        $error("pwm_compare_unit: DEAD must be within 1..2^BITS/2");
    end

    logic [DUTY_BITS-1:0] pending_q, pending_d;
    logic [DUTY_BITS-1:0] active_q, active_d;
    logic                 pending_full_q, pending_full_d;
    logic                 period_start_q;
    logic                 boundary;
    logic                 accept;
    logic                 raw_d;

    assign duty_ready_o = pending_full_q ? HS_DEASSERTED : HS_ASSERTED;
    assign boundary     = (cnt_i == CNT_LAST);
    assign accept       = (duty_valid_i == HS_ASSERTED) && (duty_ready_o == HS_ASSERTED);
    assign raw_d        = ({1'b0, cnt_i} < active_q);

    // Transfer and accept are exclusive: accept needs an empty slot, transfer a full one.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (pending_full_q && boundary) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_d      = DUTY_BITS'(clamp_duty(32'(duty_i), PERIOD_LEN));
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            period_start_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            period_start_q <= (cnt_i == '0);
        end
    end

    assign period_start_o = period_start_q;

`ifdef DEADTIME_EN
    dead_time_gen #(
        .DEAD(DEAD)
    ) u_dead_time_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_i  (raw_d),
        .pwm_o  (pwm_o),
        .pwm_n_o(pwm_n_o)
    );
`else
    logic pwm_q;
    logic pwm_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            pwm_q   <= raw_d;
            pwm_n_q <= !raw_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;
`endif

endmodule

// File: doc/pwm_compare_unit.md
Name: pwm_compare_unit

Overview:
Downstream consumer of the free-running synchronous up counter. Compares the counter value against a duty register to produce a PWM waveform.
- Duty updates arrive over a valid/ready handshake.
- Updates are double-buffered (pending → active) and applied only at period wrap, so no glitched periods.
- Sits between the counter and the pad/driver stage.

Parameters:
BITS, 4, counter width; period = 2^BITS clk cycles; must match the upstream counter.
DEAD, 2, dead-time in clk cycles; used only when DEADTIME_EN is defined; range 1..2^BITS/2.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
cnt_i  input  BITS  counter value; +1 per clk, wraps 2^BITS-1 → 0; shares clk/reset_n with the counter.
duty_i  input  BITS+1  requested high count, 0 .. 2^BITS (0% .. 100%).
duty_valid_i  input  1  duty_i valid.
duty_ready_o  output  1  pending slot empty; can accept.
pwm_o  output  1  PWM output (high side).
pwm_n_o  output  1  complementary output.
period_start_o  output  1  one-cycle pulse marking the first output cycle of each period.

Behaviour:
- Reset (async, any time, including mid-period):
  - active_duty = 0; pending cleared (empty).
  - duty_ready_o = 1; pwm_o = 0, pwm_n_o = 0, period_start_o = 0.
- Clamp: duty_i > 2^BITS is stored as 2^BITS.
- Accept: on a clk edge with duty_valid_i && duty_ready_o, the clamped duty_i goes to pending and pending becomes full. duty_ready_o drops the next cycle. Producer holds duty_i stable until accepted.
- Boundary: a cycle with cnt_i == 2^BITS-1.
  - If pending is full: active_duty <= pending, pending empties, and duty_ready_o returns to 1 the next cycle.
  - Accept on a boundary cycle with pending empty: the value lands in pending and is applied at the NEXT boundary, never the current one.
  - Accept and transfer cannot coincide, because ready is low while pending is full.
- Compare (registered, latency 1):
  - raw(t+1) = (cnt_i(t) < active_duty(t)), unsigned, BITS+1 width.
  - duty 0 gives constant low; duty 2^BITS gives constant high with no gap at wrap.
- period_start_o(t+1) = (cnt_i(t) == 0); a single-cycle pulse aligned with the first pwm bit of the period.
- Without DEADTIME_EN: pwm_o = raw, pwm_n_o = ~raw; both registered, same cycle.
- Only state kept: pending, pending_full, active_duty, output registers. No FSM beyond the pending-full flag.

Optional Feature:
DEADTIME_EN
- Defined: dead-time generator after the compare.
  - pwm_o rises DEAD cycles after raw rises; pwm_n_o rises DEAD cycles after raw falls.
  - Both fall in the same cycle raw changes, so they are never high together.
  - A raw high or low phase shorter than or equal to DEAD suppresses the corresponding output for that phase.
  - Reset clears the dead-time counter; both outputs are 0.
- Undefined: behaviour as above; DEAD is ignored.

Decomposition:
- Shared package pwm_pkg:
  - localparam-style constants DUTY_W = BITS+1 and PERIOD = 2^BITS.
  - clamp function for duty.
  - Handshake polarity constants shared with the future duty-register bus block.
- One natural sub-module, dead_time_gen (raw in → pwm_o/pwm_n_o out, DEAD-cycle counter). It is instantiated only under DEADTIME_EN.

Test Plan:
BITS=4 throughout; the upstream counter is instantiated in the bench.
- Reset, accept duty 8 mid-period → pwm_o stays 0 until the wrap; then 8 cycles high / 8 low per period. period_start_o pulses every 16 clk, aligned with the first high cycle.
- Duty 0 → pwm_o constant 0. Duty 16 → pwm_o constant 1 across the wrap. Duty 20 → same as 16 (clamp).
- Two back-to-back valids (5 then 11) → first accepted; ready low until the boundary; 5 applies at wrap 1, 11 is accepted after it and applies at wrap 2.
- Valid asserted exactly on the cnt_i==15 cycle with pending empty → applied at the following wrap (16 cycles later), not the immediate one.
- reset_n pulsed low at cnt_i=6 with pending full → outputs 0 immediately, ready=1, active_duty=0. After release, the previously pending value is never applied.
- DEADTIME_EN, DEAD=2, duty 8 → pwm_o high 6, pwm_n_o high 6, two 2-cycle both-low gaps per period. Duty 2 → pwm_o never high.
